regfile: RTL and testbench

- 32 x 32-bit integer register file, RV32I; the consumer of the writeback stage's rd_wb/rd_val_wb/rd_addr_wb outputs.
- Provides two combinational read ports to the decode stage.
- A write in the same cycle as a read of the same address is bypassed, so decode sees the value being written back.
- x0 is hardwired to zero.

---
 rtl/regfile_pkg.sv | 28 ++
 rtl/regfile_rport.sv | 52 +++++
 rtl/regfile.sv | 99 +++++++++
 tb/tb_regfile.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// regfile shared widths and control encodings.
// Imported by regfile and regfile_rport.
package regfile_pkg;

  localparam int REG_NUM      = 32;
  localparam int REG_NUM_LOG2 = 5;
  localparam int REG_ADDR_W   = REG_NUM_LOG2;
  localparam int DATA_W       = 32;

  typedef logic [DATA_W-1:0]     reg_bus_t;
  typedef logic [REG_ADDR_W-1:0] reg_addr_t;

  localparam reg_bus_t  ZERO_WORD     = '0;
  localparam reg_addr_t NOP_REG_ADDR  = '0;

  localparam logic RST_ENABLE    = 1'b1;
  localparam logic WRITE_ENABLE  = 1'b1;
  localparam logic WRITE_DISABLE = 1'b0;
  localparam logic READ_ENABLE   = 1'b1;
  localparam logic READ_DISABLE  = 1'b0;

  typedef enum logic [1:0] {
    RSEL_ZERO,
    RSEL_BYP,
    RSEL_ARR
  } rsel_e;

endpackage

// File: rtl/regfile_rport.sv
// regfile read port: reset / enable / x0 / bypass / array
// priority mux, purely combinational.
module regfile_rport
  import regfile_pkg::*;
#(
  parameter int REG_ADDR_W = regfile_pkg::REG_ADDR_W,
  parameter int DATA_W     = regfile_pkg::DATA_W
) (
  input  logic                  rst_in,
  input  logic                  re_in,
  input  logic [REG_ADDR_W-1:0] raddr_in,
  input  logic                  byp_we_in,
  input  logic [REG_ADDR_W-1:0] byp_addr_in,
  input  logic [DATA_W-1:0]     byp_data_in,
  input  logic [DATA_W-1:0]     arr_data_in,
  output logic [DATA_W-1:0]     rdata_out
);

  logic  kill;
  logic  byp_hit;
  rsel_e sel;

  // kill and byp_hit are made disjoint so the select
  // below is one-hot by construction
  assign kill = (rst_in == RST_ENABLE)
             || (re_in == READ_DISABLE)
             || (raddr_in == '0);

  assign byp_hit = !kill
                && (byp_we_in == WRITE_ENABLE)
                && (byp_addr_in == raddr_in);

  always_comb begin
    sel = RSEL_ARR;
    unique case (1'b1)
      kill:    sel = RSEL_ZERO;
      byp_hit: sel = RSEL_BYP;
      default: sel = RSEL_ARR;
    endcase
  end

  always_comb begin
    rdata_out = '0;
    unique case (sel)
      RSEL_ZERO: rdata_out = '0;
      RSEL_BYP:  rdata_out = byp_data_in;
      RSEL_ARR:  rdata_out = arr_data_in;
      default:   rdata_out = '0;
    endcase
  end

endmodule

// File: rtl/regfile.sv
// RV32I 32x32 register file, two bypassed read ports, x0 = 0.
// REGFILE_WCNT_EN adds wcnt_out, a committed-write counter.
module regfile
  import regfile_pkg::*;
#(
  parameter int REG_NUM    = regfile_pkg::REG_NUM,
  parameter int REG_ADDR_W = regfile_pkg::REG_ADDR_W,
  parameter int DATA_W     = regfile_pkg::DATA_W
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  rdy_in,
  input  logic                  we_in,
  input  logic [REG_ADDR_W-1:0] waddr_in,
  input  logic [DATA_W-1:0]     wdata_in,
  input  logic                  re1_in,
  input  logic [REG_ADDR_W-1:0] raddr1_in,
  output logic [DATA_W-1:0]     rdata1_out,
  input  logic                  re2_in,
  input  logic [REG_ADDR_W-1:0] raddr2_in,
  output logic [DATA_W-1:0]     rdata2_out
`ifdef REGFILE_WCNT_EN
  ,
  output logic [31:0]           wcnt_out
`endif
);

  logic [DATA_W-1:0] regs [REG_NUM];

  logic byp_we;
  logic commit;
  logic [DATA_W-1:0] arr1;
  logic [DATA_W-1:0] arr2;

  // a stalled write will not commit, so it must not bypass either
  assign byp_we = (we_in == WRITE_ENABLE) && rdy_in;

  assign commit = !rst_in
               && byp_we
               && (waddr_in != '0);

  always_ff @(posedge clk_in) begin
    if (rst_in == RST_ENABLE) begin
      for (int i = 0; i < REG_NUM; i++) begin
        regs[i] <= '0;
      end
    end else if (commit) begin
      regs[waddr_in] <= wdata_in;
    end
  end

  assign arr1 = regs[raddr1_in];
  assign arr2 = regs[raddr2_in];

  regfile_rport #(
    .REG_ADDR_W (REG_ADDR_W),
    .DATA_W     (DATA_W)
  ) u_rport1 (
    .rst_in      (rst_in),
    .re_in       (re1_in),
    .raddr_in    (raddr1_in),
    .byp_we_in   (byp_we),
    .byp_addr_in (waddr_in),
    .byp_data_in (wdata_in),
    .arr_data_in (arr1),
    .rdata_out   (rdata1_out)
  );

  regfile_rport #(
    .REG_ADDR_W (REG_ADDR_W),
    .DATA_W     (DATA_W)
  ) u_rport2 (
    .rst_in      (rst_in),
    .re_in       (re2_in),
    .raddr_in    (raddr2_in),
    .byp_we_in   (byp_we),
    .byp_addr_in (waddr_in),
    .byp_data_in (wdata_in),
    .arr_data_in (arr2),
    .rdata_out   (rdata2_out)
  );

`ifdef REGFILE_WCNT_EN
  logic [31:0] wcnt_q;

  always_ff @(posedge clk_in) begin
    if (rst_in == RST_ENABLE) begin
      wcnt_q <= '0;
    end else if (commit) begin
      wcnt_q <= wcnt_q + 32'd1;
    end
  end

  assign wcnt_out = wcnt_q;
`else
  // without the counter a commit only touches the array
`endif

endmodule

// File: tb/tb_regfile.sv
// regfile bench: per-cycle expected read data queued at drive
// time, popped and compared on the falling edge.
module tb_regfile;

  logic        clk_in;
  logic        rst_in;
  logic        rdy_in;
  logic        we_in;
  logic [4:0]  waddr_in;
  logic [31:0] wdata_in;
  logic        re1_in;
  logic [4:0]  raddr1_in;
  logic [31:0] rdata1_out;
  logic        re2_in;
  logic [4:0]  raddr2_in;
  logic [31:0] rdata2_out;
`ifdef REGFILE_WCNT_EN
  logic [31:0] wcnt_out;
`endif

  typedef struct {
    string       tag;
    logic [31:0] e1;
    logic [31:0] e2;
  } exp_t;

  exp_t q[$];
  int   n_cmp;
  int   n_bad;

  regfile dut (
    .clk_in     (clk_in),
    .rst_in     (rst_in),
    .rdy_in     (rdy_in),
    .we_in      (we_in),
    .waddr_in   (waddr_in),
    .wdata_in   (wdata_in),
    .re1_in     (re1_in),
    .raddr1_in  (raddr1_in),
    .rdata1_out (rdata1_out),
    .re2_in     (re2_in),
    .raddr2_in  (raddr2_in),
    .rdata2_out (rdata2_out)
`ifdef REGFILE_WCNT_EN
    ,
    .wcnt_out   (wcnt_out)
`endif
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  task automatic check(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step(
    input string       tag,
    input logic        rst,
    input logic        rdy,
    input logic        we,
    input logic [4:0]  wa,
    input logic [31:0] wd,
    input logic        r1,
    input logic [4:0]  a1,
    input logic        r2,
    input logic [4:0]  a2,
    input logic [31:0] e1,
    input logic [31:0] e2
  );
    exp_t e;
    @(posedge clk_in);
    #1;
    rst_in    = rst;
    rdy_in    = rdy;
    we_in     = we;
    waddr_in  = wa;
    wdata_in  = wd;
    re1_in    = r1;
    raddr1_in = a1;
    re2_in    = r2;
    raddr2_in = a2;
    e.tag = tag;
    e.e1  = e1;
    e.e2  = e2;
    q.push_back(e);
  endtask

  always @(negedge clk_in) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      check({e.tag, ".p1"}, rdata1_out, e.e1);
      check({e.tag, ".p2"}, rdata2_out, e.e2);
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst_in = 1'b1;
    rdy_in = 1'b1;
    we_in = 1'b0;
    waddr_in = '0;
    wdata_in = '0;
    re1_in = 1'b0;
    raddr1_in = '0;
    re2_in = 1'b0;
    raddr2_in = '0;

    // reset beats write, reads forced to 0
    step("rst_a", 1, 1, 1, 5, 32'hDEADBEEF, 1, 5, 1, 5, 0, 0);
    step("rst_b", 1, 1, 1, 5, 32'hDEADBEEF, 1, 5, 1, 5, 0, 0);
    step("rst_x5", 0, 1, 0, 5, 0, 1, 5, 1, 0, 0, 0);
`ifdef REGFILE_WCNT_EN
    check("wcnt_rst", wcnt_out, 32'd0);
`endif

    // write then read, disabled port gives 0
    step("wr_x3", 0, 1, 1, 3, 32'h12345678, 0, 3, 0, 3, 0, 0);
    step("rd_x3", 0, 1, 0, 0, 0, 1, 3, 0, 3,
         32'h12345678, 0);

    // bypass on both ports
    step("wr_x7", 0, 1, 1, 7, 32'h1, 0, 0, 0, 0, 0, 0);
    step("byp_x7", 0, 1, 1, 7, 32'hCAFEF00D, 1, 7, 1, 7,
         32'hCAFEF00D, 32'hCAFEF00D);
    step("rd_x7", 0, 1, 0, 0, 0, 1, 7, 1, 7,
         32'hCAFEF00D, 32'hCAFEF00D);

    // x0 writes discarded
    step("wr_x0", 0, 1, 1, 0, 32'hFFFFFFFF, 1, 0, 1, 0, 0, 0);
    step("rd_x0", 0, 1, 0, 0, 0, 1, 0, 1, 3,
         0, 32'h12345678);

    // rdy_in gating
    step("wr_x9", 0, 1, 1, 9, 32'h55, 1, 9, 1, 9,
         32'h55, 32'h55);
    step("rdy0_x9", 0, 0, 1, 9, 32'hAA, 1, 9, 1, 9,
         32'h55, 32'h55);
    step("rdy1_x9", 0, 1, 0, 9, 32'hAA, 1, 9, 1, 9,
         32'h55, 32'h55);

    // back-to-back, last write wins
    step("b2b_a", 0, 1, 1, 4, 32'h11, 1, 4, 1, 3,
         32'h11, 32'h12345678);
    step("b2b_b", 0, 1, 1, 4, 32'h22, 1, 4, 1, 4,
         32'h22, 32'h22);
    step("b2b_rd", 0, 1, 0, 0, 0, 1, 4, 1, 9,
         32'h22, 32'h55);
`ifdef REGFILE_WCNT_EN
    check("wcnt_6", wcnt_out, 32'd6);
`endif

    // reset clears array and read outputs
    step("rst2", 1, 1, 0, 0, 0, 1, 4, 1, 9, 0, 0);
    step("rst2_rd", 0, 1, 0, 0, 0, 1, 4, 1, 9, 0, 0);
`ifdef REGFILE_WCNT_EN
    check("wcnt_rst2", wcnt_out, 32'd0);
`endif

    // 10 commits, 2 to x0, 1 stalled
    for (int i = 1; i <= 10; i++) begin
      logic [4:0]  a;
      logic [31:0] d;
      a = 5'(i);
      d = 32'(i) * 32'h101;
      step("fill", 0, 1, 1, a, d, 1, a, 1, 0, d, 0);
    end
    step("fill_x0a", 0, 1, 1, 0, 32'h77, 1, 0, 1, 0, 0, 0);
    step("fill_x0b", 0, 1, 1, 0, 32'h78, 1, 0, 1, 0, 0, 0);
    step("fill_rdy0", 0, 0, 1, 11, 32'h99, 1, 11, 1, 0, 0, 0);
    step("idle", 0, 1, 0, 0, 0, 1, 11, 0, 0, 0, 0);
`ifdef REGFILE_WCNT_EN
    check("wcnt_10", wcnt_out, 32'd10);
`endif
    for (int i = 1; i <= 10; i++) begin
      logic [4:0] a;
      a = 5'(i);
      step("readback", 0, 1, 0, 0, 0, 1, a, 1, 5'(11 - i),
           32'(i) * 32'h101, 32'(11 - i) * 32'h101);
    end

    @(negedge clk_in);
    #1;
    check("drain", 32'(q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
